spi_ram_ctrl: RTL



---
 rtl/spi_ram_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind an SPI slave: {opcode,payload} words drive address/data
// loads, with optional burst auto-increment, an output handshake and sticky error flags.
module spi_ram_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 8,
   parameter int MEM_DEPTH  = 256,
   parameter bit AUTO_INC   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH+1:0] din,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  drop_err,
   output logic                  addr_err
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH-1);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   state_t                state, state_nxt;
   logic [ADDR_SIZE-1:0]  wr_addr, rd_addr;
   logic [1:0]            op;
   logic [DATA_WIDTH-1:0] payload;
   logic                  accept, wr_oor, rd_oor;

   assign op       = din[DATA_WIDTH+1:DATA_WIDTH];
   assign payload  = din[DATA_WIDTH-1:0];
   assign rx_ready = (state == IDLE);
   assign accept   = rx_valid && rx_ready;
   assign wr_oor   = ({1'b0, wr_addr} >= DEPTH);
   assign rd_oor   = ({1'b0, rd_addr} >= DEPTH);

   // Increment wraps at the configured depth, not at the address-width boundary.
   function automatic logic [ADDR_SIZE-1:0] step(input logic [ADDR_SIZE-1:0] a);
      return (a == LAST) ? '0 : a + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept && op == OP_RD_DATA) state_nxt = HOLD;
         HOLD: if (tx_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory has no reset so contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (!rst && accept && op == OP_WR_DATA && !wr_oor) mem[wr_addr] <= payload;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout     <= '0;
         tx_valid <= 1'b0;
         drop_err <= 1'b0;
         addr_err <= 1'b0;
         wr_addr  <= '0;
         rd_addr  <= '0;
      end else begin
         if (rx_valid && !rx_ready) drop_err <= 1'b1;
         if (state == HOLD && tx_ready) tx_valid <= 1'b0;
         if (accept) begin
            case (op)
               OP_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
               OP_WR_DATA: begin
                  // Out-of-range addresses hold so they stay out of range until reloaded.
                  if (wr_oor)        addr_err <= 1'b1;
                  else if (AUTO_INC) wr_addr  <= step(wr_addr);
               end
               OP_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
               default: begin
                  tx_valid <= 1'b1;
                  if (rd_oor) begin
                     dout     <= '0;
                     addr_err <= 1'b1;
                  end else begin
                     dout <= mem[rd_addr];
                     if (AUTO_INC) rd_addr <= step(rd_addr);
                  end
               end
            endcase
         end
      end
   end

endmodule
